// File: rtl/mod_divider_out_stage_if.sv
// Handshake/bus bundle between the divider issuer, the final cell and the result consumer.
// The slave modport is the view taken by mod_divider_out_stage.
interface mod_divider_out_stage_if #(
    parameter int QW = 26,
    parameter int RW = 14
) ();
    logic          issue_fire;
    logic          issue_ok;
    logic          pipe_valid;
    logic [QW-1:0] pipe_merchant;
    logic [RW-1:0] pipe_remainder;
    logic          pipe_dz;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_quotient;
    logic [RW-1:0] out_remainder;
    logic          out_dz;

    modport slave (
        input  issue_fire, pipe_valid, pipe_merchant, pipe_remainder, pipe_dz, out_ready,
        output issue_ok, out_valid, out_quotient, out_remainder, out_dz
    );

    modport master (
        output issue_fire, pipe_valid, pipe_merchant, pipe_remainder, pipe_dz, out_ready,
        input  issue_ok, out_valid, out_quotient, out_remainder, out_dz
    );
endinterface

// File: rtl/mod_divider_out_stage.sv
// Result FIFO with registered head output and issue-credit tracking for the
// non-stallable 26/14 divider cell pipeline.
module mod_divider_out_stage #(
    parameter int QW    = 26,
    parameter int RW    = 14,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_divider_out_stage_if.slave bus,
    output logic [CW-1:0]         fifo_level,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + QW + RW;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] out_data_q, out_data_d;
    logic          issue_ok_q, issue_ok_d;
    logic          err_q, err_d;

    logic          push, pop, full, wr_en, acc_issue, credit_dec;
    logic [EW-1:0] wr_data;

    always_comb begin
        push       = bus.pipe_valid;
        pop        = out_valid_q & bus.out_ready;
        full       = (level_q == CW'(DEPTH));
        // A pop at full frees the slot the push lands in on the same edge.
        wr_en      = push & (~full | pop);
        wr_data    = bus.pipe_dz ? {1'b1, {QW{1'b1}}, {RW{1'b0}}}
                                 : {1'b0, bus.pipe_merchant, bus.pipe_remainder};
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + CW'(wr_en) - CW'(pop);
        // Head register reloads from storage written on earlier edges only.
        out_valid_d = (level_q - CW'(pop)) != '0;
        out_data_d  = mem[rd_ptr_d];

        acc_issue  = bus.issue_fire & issue_ok_q;
        credit_dec = pop & (inflight_q != '0);
        inflight_d = inflight_q + CW'(acc_issue) - CW'(credit_dec);
        issue_ok_d = inflight_d < CW'(DEPTH);

        err_d      = err_q
                   | (push & full & ~pop)
                   | (bus.issue_fire & ~issue_ok_q)
                   | (pop & (inflight_q == '0));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            inflight_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            issue_ok_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            issue_ok_q  <= issue_ok_d;
            err_q       <= err_d;
        end
    end

    assign bus.issue_ok      = issue_ok_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_dz        = out_data_q[EW-1];
    assign bus.out_quotient  = out_data_q[QW+RW-1:RW];
    assign bus.out_remainder = out_data_q[RW-1:0];
    assign fifo_level        = level_q;
    assign err               = err_q;
endmodule

// File: tb/tb_mod_divider_out_stage.sv
// Randomised and directed bench for mod_divider_out_stage against a queue-based
// transaction model of the result FIFO and credit counter.
module tb_mod_divider_out_stage;
    localparam int QW    = 26;
    localparam int RW    = 14;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 1 + QW + RW;

    logic          clk;
    logic          rst;
    logic [CW-1:0] fifo_level;
    logic          err;

    mod_divider_out_stage_if #(.QW(QW), .RW(RW)) bus ();

    mod_divider_out_stage #(.QW(QW), .RW(RW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction model: a queue of stored results plus a visible head.
    logic [EW-1:0] m_q [$];
    logic [EW-1:0] m_head;
    logic          m_valid;
    int            m_inflight;
    logic          m_err;
    logic          m_issue_ok;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_head     = '0;
        m_valid    = 1'b0;
        m_inflight = 0;
        m_err      = 1'b0;
        m_issue_ok = 1'b1;
    endtask

    task automatic model_update();
        logic          pop;
        logic [EW-1:0] entry;
        if (rst) begin
            model_reset();
            return;
        end
        pop = m_valid && bus.out_ready;
        if (bus.issue_fire && !m_issue_ok) m_err = 1'b1;
        if (pop && m_inflight == 0) m_err = 1'b1;
        if (bus.issue_fire && m_issue_ok) m_inflight++;
        if (pop && m_inflight > 0 && !(bus.issue_fire && m_issue_ok && m_inflight == 1 && 0)) begin
            m_inflight--;
        end
        if (pop) void'(m_q.pop_front());
        m_valid = (m_q.size() > 0);
        if (m_valid) m_head = m_q[0];
        if (bus.pipe_valid) begin
            entry = bus.pipe_dz ? {1'b1, {QW{1'b1}}, {RW{1'b0}}}
                                : {1'b0, bus.pipe_merchant, bus.pipe_remainder};
            if (m_q.size() >= DEPTH) m_err = 1'b1;
            else m_q.push_back(entry);
        end
        m_issue_ok = (m_inflight < DEPTH);
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check_eq("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        check_eq("issue_ok", 64'(bus.issue_ok), 64'(m_issue_ok));
        check_eq("err", 64'(err), 64'(m_err));
        if (m_valid) begin
            check_eq("out_dz", 64'(bus.out_dz), 64'(m_head[EW-1]));
            check_eq("out_quotient", 64'(bus.out_quotient), 64'(m_head[QW+RW-1:RW]));
            check_eq("out_remainder", 64'(bus.out_remainder), 64'(m_head[RW-1:0]));
        end
    endtask

    // One clock cycle: drive away from the edge, advance the model, sample #1 after.
    task automatic step(input logic fi, input logic pv, input logic [QW-1:0] pm,
                        input logic [RW-1:0] pr, input logic pd, input logic rdy);
        @(negedge clk);
        bus.issue_fire     = fi;
        bus.pipe_valid     = pv;
        bus.pipe_merchant  = pm;
        bus.pipe_remainder = pr;
        bus.pipe_dz        = pd;
        bus.out_ready      = rdy;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    int extra;
    int pend;
    int exp_q;

    initial begin
        rst                = 1'b1;
        bus.issue_fire     = 1'b0;
        bus.pipe_valid     = 1'b0;
        bus.pipe_merchant  = '0;
        bus.pipe_remainder = '0;
        bus.pipe_dz        = 1'b0;
        bus.out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_issue_ok", 64'(bus.issue_ok), 64'd1);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_quot", 64'(bus.out_quotient), 64'd0);
        check_eq("rst_rem", 64'(bus.out_remainder), 64'd0);
        check_eq("rst_dz", 64'(bus.out_dz), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single op 1000/7.
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 26'd142, 14'd6, 0, 1);
        check_eq("single_no_bypass", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 1);
        check_eq("single_quot", 64'(bus.out_quotient), 64'd142);
        check_eq("single_rem", 64'(bus.out_remainder), 64'd6);
        step(0, 0, 0, 0, 0, 1);
        check_eq("single_drained", 64'(fifo_level), 64'd0);

        // Divide by zero.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 26'h155, 14'h3, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("dz_quot", 64'(bus.out_quotient), 64'h3FFFFFF);
        check_eq("dz_rem", 64'(bus.out_remainder), 64'd0);
        check_eq("dz_flag", 64'(bus.out_dz), 64'd1);
        step(0, 0, 0, 0, 0, 1);

        // Backpressure fill, then simultaneous push/pop at full across the wrap.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0);
        check_eq("bp_issue_ok", 64'(bus.issue_ok), 64'd0);
        for (int i = 1; i <= DEPTH; i++) step(0, 1, QW'(i), RW'(i), 0, 0);
        check_eq("bp_level", 64'(fifo_level), 64'd8);
        step(0, 0, 0, 0, 0, 0);
        check_eq("bp_hold", 64'(bus.out_quotient), 64'd1);
        extra = 0;
        exp_q = 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid) begin
                check_eq("order", 64'(bus.out_quotient), 64'(exp_q));
                exp_q++;
            end
            step(m_issue_ok && extra < 4, 1, QW'(9 + i), RW'(9 + i), 0, 1);
            if (bus.issue_fire && !(m_inflight == 0)) extra += 0;
            if (bus.issue_fire) extra++;
            check_eq("full_pp_level", 64'(fifo_level), 64'd8);
        end
        check_eq("full_pp_err", 64'(err), 64'd0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (bus.out_valid) begin
                check_eq("order", 64'(bus.out_quotient), 64'(exp_q));
                exp_q++;
            end
            step(m_issue_ok && extra < 4, 0, 0, 0, 0, 1);
            if (bus.issue_fire) extra++;
        end
        check_eq("drain_count", 64'(exp_q), 64'd13);
        check_eq("drain_issue_ok", 64'(bus.issue_ok), 64'd1);
        check_eq("drain_err", 64'(err), 64'd0);

        // Protocol errors: issue without credit, push at full.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("over_issue_err", 64'(err), 64'd1);
        check_eq("over_issue_ok", 64'(bus.issue_ok), 64'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, QW'(100 + i), RW'(i), 0, 0);
        step(0, 1, 26'h2AAAAAA, 14'h1555, 0, 0);
        check_eq("overflow_level", 64'(fifo_level), 64'd8);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1);
        check_eq("overflow_dropped", 64'(fifo_level), 64'd0);

        // Asynchronous reset with entries stored.
        for (int i = 0; i < 5; i++) step(0, 1, QW'($urandom), RW'($urandom), 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_level", 64'(fifo_level), 64'd0);
        check_eq("arst_err", 64'(err), 64'd0);
        check_eq("arst_issue_ok", 64'(bus.issue_ok), 64'd1);
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Random legal traffic with an issuer that honours credits.
        pend = 0;
        for (int i = 0; i < 3000; i++) begin
            logic fi, pv;
            fi = m_issue_ok && ($urandom_range(0, 2) != 0);
            pv = (pend > 0) && ($urandom_range(0, 2) != 0);
            pend += int'(fi) - int'(pv);
            step(fi, pv, QW'($urandom), RW'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        check_eq("rand_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
